hazard_ctrl_unit: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage pipeline. Keeps its own shadow copy of E/M/W destination information, and produces per-operand forwarding selects for the Decode and Execute stages. Also generates stall/flush controls for load-use hazards, multi-cycle data-memory loads and taken branches/jumps. It sits beside the pipeline top, fed from Decode outputs and the Execute branch decision.

---
 rtl/hazard_pkg.sv | 37 +++
 rtl/hazard_ctrl_unit_if.sv | 39 +++
 rtl/hazard_fwd_cmp.sv | 34 +++
 rtl/hazard_ctrl_unit.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg - shared types and helpers for the hazard/forwarding controller
// rev 1.0
// ============================================================================
package hazard_pkg;

    localparam int LOAD_LAT_W = 3;
    // Shadow records are sized for the largest supported configuration
    // (NREG <= 32, NSRC <= 3); narrower configurations are zero-extended.
    localparam int REG_W_MAX  = 5;
    localparam int NSRC_MAX   = 3;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                                v;
        logic [REG_W_MAX-1:0]                rd;
        logic                                wr;
        logic                                ld;
        logic [NSRC_MAX-1:0][REG_W_MAX-1:0]  rs;
        logic [NSRC_MAX-1:0]                 used;
    } stage_info_t;

    // r0 is hard-wired, so a write to it never produces a bypassable value.
    function automatic logic idx_hit(input logic                 live,
                                     input logic [REG_W_MAX-1:0] rd,
                                     input logic [REG_W_MAX-1:0] idx);
        return live && (rd != '0) && (rd == idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_unit_if - Decode/Execute hazard inputs and stall/flush/forward controls
// rev 1.0
// ============================================================================
interface hazard_ctrl_unit_if #(
    parameter int NREG = 32,
    parameter int NSRC = 3
);
    localparam int REG_W = $clog2(NREG);

    logic                    dec_valid;
    logic [NSRC*REG_W-1:0]   dec_rs;
    logic [NSRC-1:0]         dec_rs_used;
    logic [REG_W-1:0]        dec_rd;
    logic                    dec_regwrite;
    logic                    dec_is_load;
    logic                    ex_taken;

    logic                    stall_f;
    logic                    stall_d;
    logic                    stall_e;
    logic                    stall_m;
    logic                    flush_d;
    logic                    flush_e;
    logic [NSRC*2-1:0]       fwd_e;
    logic [NSRC-1:0]         fwd_d;

    modport master (
        output dec_valid, dec_rs, dec_rs_used, dec_rd, dec_regwrite, dec_is_load, ex_taken,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, fwd_e, fwd_d
    );

    modport slave (
        input  dec_valid, dec_rs, dec_rs_used, dec_rd, dec_regwrite, dec_is_load, ex_taken,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, fwd_e, fwd_d
    );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_cmp.sv
`default_nettype none
// ============================================================================
// hazard_fwd_cmp - per-operand bypass select and load-use match
// rev 1.0
// ============================================================================
module hazard_fwd_cmp
    import hazard_pkg::*;
(
    input  wire logic [REG_W_MAX-1:0] i_e_rs,
    input  wire logic                 i_e_used,
    input  wire logic [REG_W_MAX-1:0] i_dec_rs,
    input  wire logic                 i_dec_used,
    input  wire logic                 i_m_live,
    input  wire logic [REG_W_MAX-1:0] i_m_rd,
    input  wire logic                 i_w_live,
    input  wire logic [REG_W_MAX-1:0] i_w_rd,
    input  wire logic                 i_e_ld_live,
    input  wire logic [REG_W_MAX-1:0] i_e_rd,
    output fwd_sel_t                  o_fwd_e,
    output logic                      o_fwd_d,
    output logic                      o_lu_hit
);
    logic w_m_hit_e;
    logic w_w_hit_e;

    assign w_m_hit_e = i_e_used && idx_hit(i_m_live, i_m_rd, i_e_rs);
    assign w_w_hit_e = idx_hit(i_w_live, i_w_rd, i_e_rs);

    // The younger M result shadows an older W write to the same register.
    assign o_fwd_e  = w_m_hit_e ? FWD_M : (w_w_hit_e ? FWD_W : FWD_REG);
    assign o_fwd_d  = i_dec_used && idx_hit(i_w_live, i_w_rd, i_dec_rs);
    assign o_lu_hit = i_dec_used && idx_hit(i_e_ld_live, i_e_rd, i_dec_rs);
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_unit - shadow E/M/W tracking, forwarding selects, stall/flush control
// Optional perf counters when HAZARD_PERF_CNT_EN is defined.   rev 1.0
// ============================================================================
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int NSRC     = 3,
    parameter int LOAD_LAT = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_ctrl_unit_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);
    localparam int REG_W = $clog2(NREG);

    stage_info_t             r_e;
    stage_info_t             r_m;
    stage_info_t             r_w;
    stage_info_t             w_dec;
    logic [LOAD_LAT_W-1:0]   w_wait_cnt;
    logic                    w_frozen;
    logic                    w_branch;
    logic                    w_load_use;
    logic                    w_e_ld_live;
    logic                    w_m_live;
    logic                    w_w_live;
    logic [NSRC-1:0]         w_lu_hit;
    logic [NSRC*2-1:0]       w_fwd_e;
    logic [NSRC-1:0]         w_fwd_d;
    logic                    w_stall_fd;
    logic                    w_flush_d;
    logic                    w_flush_e;

    always_comb begin
        w_dec    = '0;
        w_dec.v  = hz.dec_valid;
        w_dec.rd = REG_W_MAX'(hz.dec_rd);
        w_dec.wr = hz.dec_regwrite;
        w_dec.ld = hz.dec_is_load;
        for (int k = 0; k < NSRC; k++) begin
            w_dec.rs[k]   = REG_W_MAX'(hz.dec_rs[k*REG_W +: REG_W]);
            w_dec.used[k] = hz.dec_rs_used[k];
        end
    end

    assign w_m_live    = r_m.v && r_m.wr;
    assign w_w_live    = r_w.v && r_w.wr;
    assign w_e_ld_live = r_e.v && r_e.wr && r_e.ld;

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        fwd_sel_t w_sel;
        hazard_fwd_cmp u_cmp (
            .i_e_rs      (r_e.rs[k]),
            .i_e_used    (r_e.used[k]),
            .i_dec_rs    (w_dec.rs[k]),
            .i_dec_used  (w_dec.used[k]),
            .i_m_live    (w_m_live),
            .i_m_rd      (r_m.rd),
            .i_w_live    (w_w_live),
            .i_w_rd      (r_w.rd),
            .i_e_ld_live (w_e_ld_live),
            .i_e_rd      (r_e.rd),
            .o_fwd_e     (w_sel),
            .o_fwd_d     (w_fwd_d[k]),
            .o_lu_hit    (w_lu_hit[k])
        );
        assign w_fwd_e[2*k +: 2] = w_sel;
    end

    assign w_frozen   = (w_wait_cnt != '0);
    assign w_branch   = hz.ex_taken && r_e.v;
    assign w_load_use = hz.dec_valid && (|w_lu_hit);

    // Freeze outranks a taken branch, which in turn makes a load-use stall moot.
    always_comb begin
        w_stall_fd = 1'b0;
        w_flush_d  = 1'b0;
        w_flush_e  = 1'b0;
        if (w_frozen) begin
            w_stall_fd = 1'b1;
        end else if (w_branch) begin
            w_flush_d  = 1'b1;
            w_flush_e  = 1'b1;
        end else if (w_load_use) begin
            w_stall_fd = 1'b1;
            w_flush_e  = 1'b1;
        end
    end

    assign hz.stall_f = w_stall_fd;
    assign hz.stall_d = w_stall_fd;
    assign hz.stall_e = w_frozen;
    assign hz.stall_m = w_frozen;
    assign hz.flush_d = w_flush_d;
    assign hz.flush_e = w_flush_e;
    assign hz.fwd_e   = w_fwd_e;
    assign hz.fwd_d   = w_fwd_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_e <= '0;
            r_m <= '0;
            r_w <= '0;
        end else if (w_frozen) begin
            r_w <= '0;
        end else begin
            r_w <= r_m;
            r_m <= r_e;
            r_e <= (w_branch || w_load_use) ? '0 : w_dec;
        end
    end

    if (LOAD_LAT > 0) begin : g_wait
        logic [LOAD_LAT_W-1:0] r_cnt;
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_cnt <= '0;
            end else if (w_frozen) begin
                r_cnt <= r_cnt - LOAD_LAT_W'(1);
            end else if (r_e.v && r_e.ld) begin
                r_cnt <= LOAD_LAT_W'(LOAD_LAT);
            end
        end
        assign w_wait_cnt = r_cnt;
    end else begin : g_no_wait
        assign w_wait_cnt = '0;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall_fd && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
            if (w_flush_d && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 32'd1;
        end
    end
    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`endif
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl_unit - LOAD_LAT=0 and LOAD_LAT=2 instances against a rule model
// rev 1.0
// ============================================================================
module tb_hazard_ctrl_unit;
    localparam int NREG  = 32;
    localparam int NSRC  = 3;
    localparam int REG_W = 5;

    typedef struct packed {
        logic            v;
        logic            wr;
        logic            ld;
        logic [4:0]      rd;
        logic [2:0][4:0] rs;
        logic [2:0]      used;
    } instr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  d_valid;
    logic [NSRC*REG_W-1:0] d_rs;
    logic [NSRC-1:0]       d_used;
    logic [REG_W-1:0]      d_rd;
    logic                  d_wr;
    logic                  d_ld;
    logic                  d_taken;

    hazard_ctrl_unit_if #(.NREG(NREG), .NSRC(NSRC)) if0 ();
    hazard_ctrl_unit_if #(.NREG(NREG), .NSRC(NSRC)) if1 ();

    assign if0.dec_valid = d_valid;  assign if1.dec_valid = d_valid;
    assign if0.dec_rs = d_rs;        assign if1.dec_rs = d_rs;
    assign if0.dec_rs_used = d_used; assign if1.dec_rs_used = d_used;
    assign if0.dec_rd = d_rd;        assign if1.dec_rd = d_rd;
    assign if0.dec_regwrite = d_wr;  assign if1.dec_regwrite = d_wr;
    assign if0.dec_is_load = d_ld;   assign if1.dec_is_load = d_ld;
    assign if0.ex_taken = d_taken;   assign if1.ex_taken = d_taken;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] pst0, pfl0, pst1, pfl1;
`endif

    hazard_ctrl_unit #(.NREG(NREG), .NSRC(NSRC), .LOAD_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .hz(if0)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt(pst0), .perf_flush_cnt(pfl0)
`endif
    );
    hazard_ctrl_unit #(.NREG(NREG), .NSRC(NSRC), .LOAD_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .hz(if1)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt(pst1), .perf_flush_cnt(pfl1)
`endif
    );

    // Reference model: per instance, instructions in flight at E(0), M(1), W(2).
    instr_t pipe [2][3];
    int     wcnt [2];
    int     lat  [2];
    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;

    function automatic bit hit(input instr_t s, input logic [4:0] idx);
        return s.v && s.wr && (s.rd != 5'd0) && (s.rd == idx);
    endfunction

    function automatic instr_t dec_rec();
        instr_t r;
        r.v = d_valid; r.wr = d_wr; r.ld = d_ld; r.rd = d_rd;
        for (int k = 0; k < NSRC; k++) begin
            r.rs[k]   = d_rs[k*REG_W +: REG_W];
            r.used[k] = d_used[k];
        end
        return r;
    endfunction

    function automatic bit load_use(input int i);
        instr_t d;
        bit     lu;
        d  = dec_rec();
        lu = 1'b0;
        for (int k = 0; k < NSRC; k++)
            if (d_valid && d.used[k] && pipe[i][0].ld && hit(pipe[i][0], d.rs[k])) lu = 1'b1;
        return lu;
    endfunction

    task automatic chk(input string tag, input int inst, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst%0d cycle %0d: observed %h expected %h", tag, inst, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            bit         frozen, br, lu;
            logic [5:0] exp_st, obs_st, exp_fe, obs_fe;
            logic [2:0] exp_fd, obs_fd;
            instr_t     d;
            d      = dec_rec();
            frozen = (wcnt[i] != 0);
            br     = d_taken && pipe[i][0].v;
            lu     = load_use(i);
            exp_st = {frozen || (!br && lu), frozen || (!br && lu), frozen, frozen,
                      !frozen && br, !frozen && (br || lu)};
            for (int k = 0; k < NSRC; k++) begin
                if (pipe[i][0].used[k] && hit(pipe[i][1], pipe[i][0].rs[k])) exp_fe[2*k +: 2] = 2'b10;
                else if (hit(pipe[i][2], pipe[i][0].rs[k]))                 exp_fe[2*k +: 2] = 2'b01;
                else                                                         exp_fe[2*k +: 2] = 2'b00;
                exp_fd[k] = d.used[k] && hit(pipe[i][2], d.rs[k]);
            end
            if (i == 0) begin
                obs_st = {if0.stall_f, if0.stall_d, if0.stall_e, if0.stall_m, if0.flush_d, if0.flush_e};
                obs_fe = if0.fwd_e;
                obs_fd = if0.fwd_d;
            end else begin
                obs_st = {if1.stall_f, if1.stall_d, if1.stall_e, if1.stall_m, if1.flush_d, if1.flush_e};
                obs_fe = if1.fwd_e;
                obs_fd = if1.fwd_d;
            end
            chk("stall_flush", i, {2'b00, obs_st}, {2'b00, exp_st});
            chk("fwd_e", i, {2'b00, obs_fe}, {2'b00, exp_fe});
            chk("fwd_d", i, {5'b0, obs_fd}, {5'b0, exp_fd});
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                pipe[i][0] = '0; pipe[i][1] = '0; pipe[i][2] = '0;
                wcnt[i] = 0;
            end else if (wcnt[i] != 0) begin
                pipe[i][2] = '0;
                wcnt[i]--;
            end else begin
                bit squash;
                squash = (d_taken && pipe[i][0].v) || load_use(i);
                if (pipe[i][0].v && pipe[i][0].ld) wcnt[i] = lat[i];
                pipe[i][2] = pipe[i][1];
                pipe[i][1] = pipe[i][0];
                pipe[i][0] = squash ? '0 : dec_rec();
            end
        end
    endtask

    task automatic cycle();
        #2;
        check_outputs();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
    endtask

    task automatic instr(input bit v, input int rd, input bit wr, input bit ld,
                         input int rs0, input int rs1, input int rs2,
                         input logic [2:0] used, input bit taken);
        d_valid = v; d_rd = rd[4:0]; d_wr = wr; d_ld = ld;
        d_rs = {rs2[4:0], rs1[4:0], rs0[4:0]};
        d_used = used; d_taken = taken;
        cycle();
    endtask

    task automatic nop(input int n);
        for (int j = 0; j < n; j++) instr(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    endtask

    initial begin
        lat[0] = 0; lat[1] = 2;
        wcnt[0] = 0; wcnt[1] = 0;
        rst = 1'b0;
        d_valid = 0; d_rs = '0; d_used = '0; d_rd = '0; d_wr = 0; d_ld = 0; d_taken = 0;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        nop(2);
        rst = 1'b1;

        // RAW from M, then from W with an independent instruction between
        instr(1, 5, 1, 0, 1, 2, 0, 3'b011, 0);
        instr(1, 6, 1, 0, 5, 7, 0, 3'b011, 0);
        nop(3);
        instr(1, 5, 1, 0, 1, 2, 0, 3'b011, 0);
        instr(1, 9, 1, 0, 10, 11, 0, 3'b011, 0);
        instr(1, 6, 1, 0, 5, 7, 0, 3'b011, 0);
        nop(3);

        // load-use: consumer is held in Decode for the stall cycle
        instr(1, 3, 1, 1, 2, 0, 0, 3'b001, 0);
        instr(1, 4, 1, 0, 3, 1, 0, 3'b011, 0);
        instr(1, 4, 1, 0, 3, 1, 0, 3'b011, 0);
        nop(4);

        // memory wait
        instr(1, 8, 1, 1, 2, 0, 0, 3'b001, 0);
        nop(5);

        // taken branch sitting in E while the load is frozen in M
        instr(1, 8, 1, 1, 2, 0, 0, 3'b001, 0);
        instr(1, 0, 0, 0, 1, 2, 0, 3'b011, 0);
        instr(1, 12, 1, 0, 13, 14, 0, 3'b011, 1);
        instr(1, 12, 1, 0, 13, 14, 0, 3'b011, 1);
        instr(1, 12, 1, 0, 13, 14, 0, 3'b011, 1);
        nop(4);

        // r0 writes never forward or stall
        instr(1, 0, 1, 0, 1, 2, 0, 3'b011, 0);
        instr(1, 6, 1, 0, 0, 0, 0, 3'b011, 0);
        nop(1);
        instr(1, 0, 1, 1, 1, 0, 0, 3'b001, 0);
        instr(1, 6, 1, 0, 0, 0, 0, 3'b011, 0);
        nop(4);

        // reset in the middle of a memory wait
        instr(1, 8, 1, 1, 2, 0, 0, 3'b001, 0);
        nop(1);
        rst = 1'b0;
        nop(1);
        rst = 1'b1;
        nop(3);

        // random traffic over a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) != 0);
            instr(($urandom_range(0, 7) != 0), $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
        end
        rst = 1'b1;
        nop(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
